alu_rmw_seq: RTL and testbench

Read-modify-write sequencer for the 65C816 core. It runs the memory RMW instructions ASL, ROL, LSR, ROR, DEC, INC, TRB and TSB in 8- or 16-bit width. It owns the byte-wide memory bus for the duration of the instruction and configures the shared combinational ALU: operand select, fstOp/secOp/fc and width. It latches the result and hands masked N/Z/C updates back to the P register.

---
 rtl/alu_rmw_seq_if.sv | 27 ++
 rtl/alu_rmw_seq.sv | 247 ++++++++++++++++++++++++
 tb/tb_alu_rmw_seq.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rmw_seq_if.sv
// Byte-wide memory bus owned by the RMW sequencer for the duration of an instruction.
interface alu_rmw_seq_if;
    logic [23:0] MEM_ADDR;
    logic        MEM_RD;
    logic        MEM_WR;
    logic [7:0]  MEM_WDATA;
    logic [7:0]  MEM_RDATA;
    logic        MEM_RDY;

    modport master (
        output MEM_ADDR,
        output MEM_RD,
        output MEM_WR,
        output MEM_WDATA,
        input  MEM_RDATA,
        input  MEM_RDY
    );

    modport slave (
        input  MEM_ADDR,
        input  MEM_RD,
        input  MEM_WR,
        input  MEM_WDATA,
        output MEM_RDATA,
        output MEM_RDY
    );
endinterface

// File: rtl/alu_rmw_seq.sv
// 65C816 read-modify-write sequencer: reads the operand, drives the shared ALU,
// writes the result back high byte first and reports masked N/Z/C updates.
module alu_rmw_seq (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE,
    input  logic                 START,
    input  logic [2:0]           OP,
    input  logic                 W16,
    input  logic                 E,
    input  logic [23:0]          ADDR,
    input  logic [15:0]          ACC,
    input  logic                 CI,
    alu_rmw_seq_if.master        mem,
    output logic [15:0]          ALU_L,
    output logic [15:0]          ALU_R,
    output logic [2:0]           ALU_FSTOP,
    output logic [2:0]           ALU_SECOP,
    output logic                 ALU_FC,
    output logic                 ALU_W16,
    output logic                 ALU_CI,
    input  logic [15:0]          ALU_RES,
    input  logic                 ALU_CO,
    input  logic                 ALU_ZO,
    input  logic                 ALU_SO,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 FLAG_WE,
    output logic [2:0]           FLAG_MASK,
    output logic [2:0]           FLAG_NZC
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_MODIFY,
        S_WR_HI,
        S_WR_LO
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        w16_q, w16_d;
    logic        e_q, e_d;
    logic [23:0] addr_q, addr_d;
    logic [23:0] addr_hi_d;
    logic [15:0] acc_q, acc_d;
    logic        ci_q, ci_d;
    logic [15:0] r_q, r_d;
    logic [15:0] res_q, res_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        flag_we_q, flag_we_d;
    logic [2:0]  flag_mask_q, flag_mask_d;
    logic [2:0]  flag_nzc_q, flag_nzc_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        w16_d       = w16_q;
        e_d         = e_q;
        addr_d      = addr_q;
        acc_d       = acc_q;
        ci_d        = ci_q;
        r_d         = r_q;
        res_d       = res_q;
        flag_mask_d = flag_mask_q;
        flag_nzc_d  = flag_nzc_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    op_d    = OP;
                    w16_d   = W16 & ~E;
                    e_d     = E;
                    addr_d  = ADDR;
                    acc_d   = ACC;
                    ci_d    = CI;
                    r_d     = 16'h0000;
                    state_d = S_RD_LO;
                end
            end
            S_RD_LO: begin
                if (mem.MEM_RDY) begin
                    r_d[7:0] = mem.MEM_RDATA;
                    state_d  = w16_q ? S_RD_HI : S_MODIFY;
                end
            end
            S_RD_HI: begin
                if (mem.MEM_RDY) begin
                    r_d[15:8] = mem.MEM_RDATA;
                    state_d   = S_MODIFY;
                end
            end
            S_MODIFY: begin
                // Native mode has no bus cycle here, so only the dummy write waits.
                if (!e_q || mem.MEM_RDY) begin
                    res_d      = ALU_RES;
                    flag_nzc_d = {ALU_SO, ALU_ZO, ALU_CO};
                    case (op_q[2:1])
                        2'b10:   flag_mask_d = 3'b110;
                        2'b11:   flag_mask_d = 3'b010;
                        default: flag_mask_d = 3'b111;
                    endcase
                    state_d = w16_q ? S_WR_HI : S_WR_LO;
                end
            end
            S_WR_HI: begin
                if (mem.MEM_RDY) begin
                    state_d = S_WR_LO;
                end
            end
            S_WR_LO: begin
                if (mem.MEM_RDY) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d != S_IDLE);
        flag_we_d = done_d;
        addr_hi_d = addr_d + 24'd1;

        // Bus outputs are registered copies of what the next state presents.
        mem_addr_d  = 24'h000000;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_wdata_d = 8'h00;
        case (state_d)
            S_RD_LO: begin
                mem_addr_d = addr_d;
                mem_rd_d   = 1'b1;
            end
            S_RD_HI: begin
                mem_addr_d = addr_hi_d;
                mem_rd_d   = 1'b1;
            end
            S_MODIFY: begin
                mem_addr_d  = addr_d;
                mem_wr_d    = e_d;
                mem_wdata_d = r_d[7:0];
            end
            S_WR_HI: begin
                mem_addr_d  = addr_hi_d;
                mem_wr_d    = 1'b1;
                mem_wdata_d = res_d[15:8];
            end
            S_WR_LO: begin
                mem_addr_d  = addr_d;
                mem_wr_d    = 1'b1;
                mem_wdata_d = res_d[7:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            w16_q       <= 1'b0;
            e_q         <= 1'b0;
            addr_q      <= 24'h000000;
            acc_q       <= 16'h0000;
            ci_q        <= 1'b0;
            r_q         <= 16'h0000;
            res_q       <= 16'h0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            flag_we_q   <= 1'b0;
            flag_mask_q <= 3'b000;
            flag_nzc_q  <= 3'b000;
            mem_addr_q  <= 24'h000000;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
        end else if (CE) begin
            state_q     <= state_d;
            op_q        <= op_d;
            w16_q       <= w16_d;
            e_q         <= e_d;
            addr_q      <= addr_d;
            acc_q       <= acc_d;
            ci_q        <= ci_d;
            r_q         <= r_d;
            res_q       <= res_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            flag_we_q   <= flag_we_d;
            flag_mask_q <= flag_mask_d;
            flag_nzc_q  <= flag_nzc_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // ALU control is decoded from the latched opcode and parked at zero when idle.
    always_comb begin
        ALU_FSTOP = 3'b000;
        ALU_SECOP = 3'b000;
        ALU_FC    = 1'b0;
        if (busy_q) begin
            ALU_SECOP = 3'b100;
            case (op_q)
                3'd4:    ALU_FSTOP = 3'b110;
                3'd5:    ALU_FSTOP = 3'b111;
                3'd6: begin
                    ALU_FSTOP = 3'b100;
                    ALU_SECOP = 3'b101;
                end
                3'd7: begin
                    ALU_FSTOP = 3'b100;
                    ALU_SECOP = 3'b101;
                    ALU_FC    = 1'b1;
                end
                default: ALU_FSTOP = op_q;
            endcase
        end
    end

    assign ALU_W16       = busy_q & w16_q;
    assign ALU_L         = acc_q;
    assign ALU_R         = r_q;
    assign ALU_CI        = ci_q;

    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign FLAG_WE       = flag_we_q;
    assign FLAG_MASK     = flag_mask_q;
    assign FLAG_NZC      = flag_nzc_q;

    assign mem.MEM_ADDR  = mem_addr_q;
    assign mem.MEM_RD    = mem_rd_q;
    assign mem.MEM_WR    = mem_wr_q;
    assign mem.MEM_WDATA = mem_wdata_q;

endmodule

// File: tb/tb_alu_rmw_seq.sv
// Bench for alu_rmw_seq: behavioural ALU and byte memory around the DUT, fixed
// vectors, wait-state/reset/clock-enable sequences and randomized instructions.
module tb_alu_rmw_seq;

    logic        clk = 1'b0;
    logic        rst, ce, start, w16, e, ci, rdy;
    logic [2:0]  op;
    logic [23:0] addr;
    logic [15:0] acc;
    logic [15:0] alu_l, alu_r, alu_res;
    logic [2:0]  alu_fstop, alu_secop;
    logic        alu_fc, alu_w16, alu_ci, alu_co, alu_zo, alu_so;
    logic        busy, done, flag_we;
    logic [2:0]  flag_mask, flag_nzc;

    alu_rmw_seq_if mif();
    assign mif.MEM_RDY = rdy;

    always #5 clk = ~clk;

    alu_rmw_seq dut (
        .CLK(clk), .RST(rst), .CE(ce), .START(start), .OP(op), .W16(w16), .E(e),
        .ADDR(addr), .ACC(acc), .CI(ci), .mem(mif),
        .ALU_L(alu_l), .ALU_R(alu_r), .ALU_FSTOP(alu_fstop), .ALU_SECOP(alu_secop),
        .ALU_FC(alu_fc), .ALU_W16(alu_w16), .ALU_CI(alu_ci), .ALU_RES(alu_res),
        .ALU_CO(alu_co), .ALU_ZO(alu_zo), .ALU_SO(alu_so),
        .BUSY(busy), .DONE(done), .FLAG_WE(flag_we), .FLAG_MASK(flag_mask), .FLAG_NZC(flag_nzc)
    );

    // Shared ALU, modelled from its encoding table.
    logic [15:0] m_r, m_l, m_res;
    logic        m_top;
    always_comb begin
        m_r   = alu_w16 ? alu_r : {8'h00, alu_r[7:0]};
        m_l   = alu_w16 ? alu_l : {8'h00, alu_l[7:0]};
        m_top = alu_w16 ? m_r[15] : m_r[7];
        m_res = 16'h0000;
        alu_co = 1'b0;
        case ({alu_secop, alu_fstop, alu_fc})
            7'b100_000_0: begin m_res = m_r << 1; alu_co = m_top; end
            7'b100_001_0: begin m_res = (m_r << 1) | {15'h0, alu_ci}; alu_co = m_top; end
            7'b100_010_0: begin m_res = m_r >> 1; alu_co = m_r[0]; end
            7'b100_011_0: begin
                m_res  = (m_r >> 1) | (alu_ci ? (alu_w16 ? 16'h8000 : 16'h0080) : 16'h0000);
                alu_co = m_r[0];
            end
            7'b100_110_0: m_res = m_r - 16'd1;
            7'b100_111_0: m_res = m_r + 16'd1;
            7'b101_100_0: m_res = m_r & ~m_l;
            7'b101_100_1: m_res = m_r | m_l;
            default: ;
        endcase
        if (!alu_w16) m_res[15:8] = 8'h00;
        alu_res = m_res;
        alu_so  = alu_w16 ? m_res[15] : m_res[7];
        alu_zo  = (alu_secop == 3'b101) ? ((m_r & m_l) == 16'h0000) : (m_res == 16'h0000);
    end

    typedef struct packed { logic wr; logic [23:0] a; logic [7:0] d; } bus_t;
    logic [7:0] mem [logic [23:0]];
    bus_t       log_q [$];

    always @(negedge clk)
        mif.MEM_RDATA = mem.exists(mif.MEM_ADDR) ? mem[mif.MEM_ADDR] : 8'hEE;

    always @(posedge clk) begin
        if (!rst && ce && rdy && (mif.MEM_RD || mif.MEM_WR)) begin
            log_q.push_back({mif.MEM_WR, mif.MEM_ADDR, mif.MEM_WR ? mif.MEM_WDATA : mif.MEM_RDATA});
            if (mif.MEM_WR) mem[mif.MEM_ADDR] = mif.MEM_WDATA;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    logic [6:0] enc_tab [8];

    // Instruction semantics in plain arithmetic on the operand value.
    function automatic void ref_rmw(input logic [2:0] f_op, input bit is16, input int unsigned m_in,
                                    input int unsigned acc_in, input bit f_ci, output int unsigned res,
                                    output logic [2:0] mask, output logic [2:0] nzc);
        int unsigned md, msb, m, a;
        bit n, z, c;
        md = is16 ? 65536 : 256;
        msb = md / 2;
        m = m_in % md;
        a = acc_in % md;
        c = 1'b0;
        res = 0;
        case (f_op)
            3'd0: begin res = (m * 2) % md; c = (m >= msb); end
            3'd1: begin res = (m * 2 + (f_ci ? 1 : 0)) % md; c = (m >= msb); end
            3'd2: begin res = m / 2; c = (m % 2) == 1; end
            3'd3: begin res = m / 2 + (f_ci ? msb : 0); c = (m % 2) == 1; end
            3'd4: res = (m + md - 1) % md;
            3'd5: res = (m + 1) % md;
            3'd6: res = m & ~a & (md - 1);
            default: res = m | a;
        endcase
        n = (res >= msb);
        z = (f_op >= 6) ? ((m & a) == 0) : (res == 0);
        mask = (f_op < 4) ? 3'b111 : (f_op < 6) ? 3'b110 : 3'b010;
        nzc = {n, z, c};
    endfunction

    task automatic check_log(input string name, input logic [23:0] a, input bit ee, input bit is16,
                             input logic [15:0] m, input logic [15:0] res);
        bus_t exp_q [$];
        logic [23:0] ah;
        ah = a + 24'd1;
        exp_q.push_back({1'b0, a, m[7:0]});
        if (is16) exp_q.push_back({1'b0, ah, m[15:8]});
        if (ee)   exp_q.push_back({1'b1, a, m[7:0]});
        if (is16) exp_q.push_back({1'b1, ah, res[15:8]});
        exp_q.push_back({1'b1, a, res[7:0]});
        chk({name, "_nbus"}, 40'(log_q.size()), 40'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("%s_bus%0d", name, i), 40'(log_q[i]), 40'(exp_q[i]));
    endtask

    int obs_cycles;
    bit obs_got, obs_conflict;
    task automatic wait_done(input bit rnd);
        obs_got = 1'b0;
        obs_conflict = 1'b0;
        obs_cycles = 1;
        for (int k = 0; k < 400; k++) begin
            if (rnd) begin
                ce  = ($urandom_range(0, 3) != 0);
                rdy = ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
            if (mif.MEM_RD && mif.MEM_WR) obs_conflict = 1'b1;
            if (!busy && (mif.MEM_RD || mif.MEM_WR)) obs_conflict = 1'b1;
            if (done) begin
                obs_got = 1'b1;
                break;
            end
            obs_cycles++;
        end
        ce  = 1'b1;
        rdy = 1'b1;
    endtask

    // Called at a negedge; START goes up immediately.
    task automatic run_instr(input string name, input logic [2:0] i_op, input logic i_w16, input logic i_e,
                             input logic [23:0] i_addr, input logic [15:0] i_acc, input logic i_ci,
                             input logic [15:0] i_m, input bit rnd, input logic [15:0] x_res,
                             input logic [2:0] x_mask, input logic [2:0] x_nzc, input int x_cycles);
        logic [23:0] ahi;
        logic        w16e;
        int          acc_wait;
        ahi  = i_addr + 24'd1;
        w16e = i_w16 & ~i_e;
        mem[i_addr] = i_m[7:0];
        if (w16e) mem[ahi] = i_m[15:8];
        log_q.delete();
        op = i_op; w16 = i_w16; e = i_e; addr = i_addr; acc = i_acc; ci = i_ci;
        start = 1'b1;
        acc_wait = 0;
        do begin
            if (rnd) begin
                ce  = ($urandom_range(0, 3) != 0);
                rdy = ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
            acc_wait++;
        end while (!busy && acc_wait < 100);
        start = 1'b0;
        chk({name, "_accept"}, 40'(busy), 40'd1);
        if (!rnd) chk({name, "_accept_lat"}, 40'(acc_wait), 40'd1);
        chk({name, "_alu_enc"}, 40'({alu_fstop, alu_secop, alu_fc}), 40'(enc_tab[i_op]));
        chk({name, "_alu_w16"}, 40'(alu_w16), 40'(w16e));
        chk({name, "_alu_ci"}, 40'(alu_ci), 40'(i_ci));
        wait_done(rnd);
        chk({name, "_done"}, 40'(obs_got), 40'd1);
        chk({name, "_flag_we"}, 40'(flag_we), 40'd1);
        chk({name, "_busy_low"}, 40'(busy), 40'd0);
        chk({name, "_strobes"}, 40'(obs_conflict), 40'd0);
        chk({name, "_mask"}, 40'(flag_mask), 40'(x_mask));
        chk({name, "_nzc"}, 40'(flag_nzc & x_mask), 40'(x_nzc & x_mask));
        if (x_cycles != 0) chk({name, "_cycles"}, 40'(obs_cycles), 40'(x_cycles));
        check_log(name, i_addr, i_e, w16e, i_m, x_res);
        $display("instr %s op=%0d w16=%0d e=%0d addr=%06h acc=%04h ci=%0d m=%04h res=%04h nzc=%03b mask=%03b",
                 name, i_op, w16e, i_e, i_addr, i_acc, i_ci, i_m, x_res, flag_nzc, x_mask);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic        w16, e;
        logic [23:0] addr;
        logic [15:0] acc;
        logic        ci;
        logic [15:0] m, res;
        logic [2:0]  mask, nzc;
        int          cycles;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int unsigned x_res_i;
        logic [2:0]  x_mask, x_nzc, r_op;
        logic [23:0] r_addr;
        logic        r_w16, r_e, r_ci;
        logic [15:0] r_m, r_acc;
        bit          bad;

        enc_tab = '{7'b000_100_0, 7'b001_100_0, 7'b010_100_0, 7'b011_100_0,
                    7'b110_100_0, 7'b111_100_0, 7'b100_101_0, 7'b100_101_1};
        vecs[0] = '{"asl8",  3'd0, 1'b0, 1'b0, 24'h001000, 16'h0000, 1'b0, 16'h0081, 16'h0002, 3'b111, 3'b001, 3};
        vecs[1] = '{"ror16", 3'd3, 1'b1, 1'b0, 24'h00FFFF, 16'h0000, 1'b1, 16'h0001, 16'h8000, 3'b111, 3'b101, 5};
        vecs[2] = '{"inc16", 3'd5, 1'b1, 1'b0, 24'h002000, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 3'b110, 3'b010, 5};
        vecs[3] = '{"tsb8",  3'd7, 1'b0, 1'b0, 24'h002100, 16'h000F, 1'b0, 16'h00F0, 16'h00FF, 3'b010, 3'b010, 3};
        vecs[4] = '{"trb8",  3'd6, 1'b0, 1'b0, 24'h002200, 16'h000F, 1'b0, 16'h003C, 16'h0030, 3'b010, 3'b000, 3};
        vecs[5] = '{"dec_e", 3'd4, 1'b1, 1'b1, 24'h002300, 16'h0000, 1'b0, 16'h0000, 16'h00FF, 3'b110, 3'b100, 3};

        // Reset with CE low: reset must still win.
        rst = 1'b1; ce = 1'b0; start = 1'b0; rdy = 1'b1;
        op = 3'd0; w16 = 1'b0; e = 1'b0; addr = 24'h0; acc = 16'h0; ci = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 40'({busy, done, flag_we, mif.MEM_RD, mif.MEM_WR}), 40'd0);
        chk("rst_flags", 40'({flag_mask, flag_nzc}), 40'd0);
        chk("rst_bus", 40'({mif.MEM_ADDR, mif.MEM_WDATA}), 40'd0);
        chk("rst_alu_ops", 40'({alu_fstop, alu_secop, alu_fc, alu_w16, alu_ci}), 40'd0);
        chk("rst_alu_lr", 40'({alu_l, alu_r}), 40'd0);
        rst = 1'b0; ce = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_instr(vecs[i].name, vecs[i].op, vecs[i].w16, vecs[i].e, vecs[i].addr, vecs[i].acc,
                      vecs[i].ci, vecs[i].m, 1'b0, vecs[i].res, vecs[i].mask, vecs[i].nzc, vecs[i].cycles);

        // DONE/FLAG_WE stretch while CE is low.
        run_instr("inc8", 3'd5, 1'b0, 1'b0, 24'h002400, 16'h0000, 1'b0, 16'h007F, 1'b0,
                  16'h0080, 3'b110, 3'b100, 3);
        ce = 1'b0;
        @(negedge clk);
        chk("ce_hold_done", 40'({done, flag_we}), 40'b11);
        @(negedge clk);
        chk("ce_hold_done2", 40'({done, flag_we}), 40'b11);
        ce = 1'b1;
        @(negedge clk);
        chk("ce_release_done", 40'({done, flag_we}), 40'b00);

        // Three wait states in RD_HI with a stray START that must be ignored.
        mem[24'h003000] = 8'h34; mem[24'h003001] = 8'h12;
        log_q.delete();
        op = 3'd0; w16 = 1'b1; e = 1'b0; addr = 24'h003000; acc = 16'h0; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ws_rdlo", 40'({mif.MEM_ADDR, mif.MEM_RD, mif.MEM_WR}), 40'({24'h003000, 2'b10}));
        @(negedge clk);
        chk("ws_rdhi", 40'({mif.MEM_ADDR, mif.MEM_RD, mif.MEM_WR}), 40'({24'h003001, 2'b10}));
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("ws_hold%0d", k), 40'({mif.MEM_ADDR, mif.MEM_RD, mif.MEM_WR, busy}),
                40'({24'h003001, 3'b101}));
            start = (k == 0);
            op    = 3'd5;
            if (k == 2) rdy = 1'b1;
        end
        wait_done(1'b0);
        chk("ws_done", 40'(obs_got), 40'd1);
        check_log("ws", 24'h003000, 1'b0, 1'b1, 16'h1234, 16'h2468);
        $display("instr ws asl16 addr=003000 m=1234 wait=3 stray_start");
        @(negedge clk);
        chk("ws_no_restart", 40'(busy), 40'd0);

        // Reset while the high byte is being written.
        mem[24'h004000] = 8'hFF; mem[24'h004001] = 8'h00;
        log_q.delete();
        op = 3'd5; w16 = 1'b1; e = 1'b0; addr = 24'h004000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wrhi", 40'({mif.MEM_ADDR, mif.MEM_WR, mif.MEM_WDATA}), 40'({24'h004001, 1'b1, 8'h01}));
        rdy = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_mid", 40'({busy, done, flag_we, mif.MEM_RD, mif.MEM_WR}), 40'd0);
        rst = 1'b0; rdy = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || flag_we || busy) bad = 1'b1;
        end
        chk("rst_no_done", 40'(bad), 40'd0);
        chk("rst_reads_only", 40'(log_q.size()), 40'd2);
        $display("instr rst_wrhi inc16 addr=004000 aborted");

        // Randomized instructions with random CE and wait states.
        for (int t = 0; t < 40; t++) begin
            r_op   = 3'($urandom_range(0, 7));
            r_w16  = 1'($urandom_range(0, 1));
            r_e    = ($urandom_range(0, 3) == 0);
            r_addr = ($urandom_range(0, 5) == 0) ? 24'hFFFFFF : 24'($urandom);
            r_acc  = 16'($urandom);
            r_m    = 16'($urandom);
            r_ci   = 1'($urandom_range(0, 1));
            ref_rmw(r_op, r_w16 & ~r_e, r_m, r_acc, r_ci, x_res_i, x_mask, x_nzc);
            if (!(r_w16 & ~r_e)) r_m[15:8] = 8'h00;
            run_instr($sformatf("rnd%0d", t), r_op, r_w16, r_e, r_addr, r_acc, r_ci, r_m, 1'b1,
                      16'(x_res_i), x_mask, x_nzc, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
